sram_responder: RTL
===================

Name: sram_responder

Overview:
- Clocked, synthesizable responder for the external 256Kx16 SRAM pin interface. It sits on the device side of the SRAM pins and answers the memory-side controller.
- Used as the device model in the ARM lab testbenches, and on-chip as an SRAM stand-in when the board part is unavailable.
- Stores written data with byte-lane masking and returns read data on the shared DQ bus after a programmable latency.
- Exposes access counters and a sticky protocol-error flag for verification.

Parameters:
- ADDR_W, 18, SRAM address width on the pins.
- DATA_W, 16, DQ width; must be 16, since lanes are UB=[15:8] and LB=[7:0].
- DEPTH_W, 10, implemented words = 2^DEPTH_W; array index = SRAM_ADDR[DEPTH_W-1:0], so higher addresses alias.
- READ_LAT, 1, cycles from a sampled read request to DQ valid; legal range 1..4.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-low (0 = reset at the next posedge).
- SRAM_DQ  inout  16  shared data bus; driven only per the read rules below, otherwise high-Z.
- SRAM_ADDR  in  18  word address.
- SRAM_WE_N  in  1  write enable, active-low.
- SRAM_UB_N  in  1  upper byte enable, active-low.
- SRAM_LB_N  in  1  lower byte enable, active-low.
- SRAM_CE_N  in  1  chip enable, active-low.
- SRAM_OE_N  in  1  output enable, active-low.
- wr_count  out  16  number of write cycles accepted; wraps FFFF->0000.
- rd_count  out  16  number of read requests accepted (WAIT entries); wraps.
- drive_en  out  1  1 while the block drives any DQ lane.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Access decode, sampled at posedge:
  - sel = !CE_N && (!UB_N || !LB_N).
  - wr = sel && !WE_N. WE overrides OE.
  - rd = sel && WE_N && !OE_N.
- Reset (rst=0 at posedge):
  - state=IDLE, count=0, data_q=0, wr_count=0, rd_count=0, proto_err=0.
  - drive_en=0 from that edge on.
  - Array contents are NOT cleared.
  - Reset overrides any simultaneous access; the write is dropped.
- Write:
  - On a posedge with wr: mem[idx][15:8] <= DQ[15:8] if !UB_N; mem[idx][7:0] <= DQ[7:0] if !LB_N.
  - wr_count increments by 1.
  - A new write every cycle is allowed.
- State machine (IDLE, WAIT, DRIVE):
  - IDLE:
    - rd -> capture addr_q = ADDR; rd_count+1.
    - If READ_LAT=1: load data_q = mem[idx] and go to DRIVE.
    - Else: count = READ_LAT-2, go to WAIT.
  - WAIT:
    - wr or !rd -> IDLE.
    - ADDR != addr_q -> recapture, restart count at READ_LAT-2, rd_count+1.
    - count==0 -> load data_q = mem[idx], go to DRIVE.
    - Otherwise count-1.
  - DRIVE:
    - wr or !rd -> IDLE.
    - ADDR != addr_q -> treat as a new request, same as the IDLE rd branch; the READ_LAT=1 case stays in DRIVE with reloaded data.
    - Otherwise reload data_q = mem[idx] every cycle, so same-address data written elsewhere is reflected.
- Read latency: a request sampled at edge N gives data valid on DQ after edge N+READ_LAT-1, i.e. valid in cycle N+READ_LAT.
- DQ drive (combinational on live pins, for same-cycle turnaround):
  - Upper lane driven with data_q[15:8] iff state==DRIVE && !CE_N && !OE_N && WE_N && !UB_N.
  - Lower lane likewise with LB_N.
  - Disabled lanes are high-Z.
  - drive_en = OR of the two lane enables.
- proto_err is set (sticky until reset) on any posedge where:
  - !CE_N && UB_N && LB_N && (!WE_N || !OE_N) — an access with no lanes enabled; or
  - any SRAM_ADDR bit at or above DEPTH_W is 1 while sel — an aliased access.
- Counter wrap is silent.

Test Plan:
- Write then read: write 0xBEEF @0x00010, then 0xDEAD @0x00011; read both with READ_LAT=1 -> DQ=0xBEEF in the cycle after the read is sampled, then 0xDEAD; wr_count=2, rd_count=2.
- Byte lanes: write 0x1234 @5, then write 0xAB00 with UB_N=0, LB_N=1 -> read @5 returns 0xAB34. Read with LB_N=1 -> DQ[7:0]=Z, DQ[15:8]=0xAB.
- Latency: READ_LAT=3, read @7 (holding 0x5555) sampled at edge N -> DQ high-Z through cycle N+2, 0x5555 in cycle N+3. Changing ADDR during WAIT restarts the count and gives rd_count+1.
- Turnaround: DRIVE on @3, then WE_N=0 in the next cycle -> drive_en=0 combinationally in that cycle; the write lands; the next read returns the new value.
- Reset mid-read: rst=0 at the edge during WAIT -> state IDLE, DQ high-Z, counters=0; memory data still readable after rst=1.
- Alias and error: DEPTH_W=10, write 0x0F0F @0x00400 -> read @0x00000 returns 0x0F0F; proto_err=1. Access with UB_N=LB_N=1 also sets proto_err, which stays set until reset.

Source files
------------

// File: rtl/sram_responder.sv
// sram_responder: device-side responder for a 256Kx16 asynchronous SRAM pin
// interface. Stores writes with byte-lane masking and answers reads on the
// shared DQ bus after READ_LAT cycles. It also keeps access counters and a
// sticky protocol-error flag.
//
// Ports:
//   clk        system clock, all state updates on posedge
//   rst        synchronous active-low reset
//   SRAM_DQ    shared 16-bit data bus (UB = [15:8], LB = [7:0])
//   SRAM_ADDR  word address; bits at or above DEPTH_W alias onto the array
//   SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  active-low strobes
//   wr_count   accepted write cycles (wraps)
//   rd_count   accepted read requests (wraps)
//   drive_en   1 while any DQ lane is driven (combinational on live pins)
//   proto_err  sticky protocol-error flag
module sram_responder #(
  parameter int unsigned ADDR_W   = 18,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DEPTH_W  = 10,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count,
  output logic              drive_en,
  output logic              proto_err
);

  localparam int unsigned WORDS      = 1 << DEPTH_W;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned LAT_RELOAD = (READ_LAT > 1) ? READ_LAT - 2 : 0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRIVE} state_t;

  logic [DATA_W-1:0] mem [WORDS];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q;
  logic              load, rd_inc, new_req;

  logic               sel, wr, rd, addr_hi, err_c, ub_en, lb_en;
  logic [DEPTH_W-1:0] idx;

  // Access decode on the live pins; WE overrides OE.
  assign sel     = !SRAM_CE_N && (!SRAM_UB_N || !SRAM_LB_N);
  assign wr      = sel && !SRAM_WE_N;
  assign rd      = sel && SRAM_WE_N && !SRAM_OE_N;
  assign idx     = SRAM_ADDR[DEPTH_W-1:0];
  assign addr_hi = |SRAM_ADDR[ADDR_W-1:DEPTH_W];
  assign err_c   = (!SRAM_CE_N && SRAM_UB_N && SRAM_LB_N && (!SRAM_WE_N || !SRAM_OE_N))
                 || (addr_hi && sel);

  // Lane enables follow the live pins so a write turnaround releases DQ in the same cycle.
  assign ub_en    = (state_q == ST_DRIVE) && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N && !SRAM_UB_N;
  assign lb_en    = (state_q == ST_DRIVE) && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N && !SRAM_LB_N;
  assign drive_en = ub_en || lb_en;

  assign SRAM_DQ[15:8] = ub_en ? data_q[15:8] : 8'bz;
  assign SRAM_DQ[7:0]  = lb_en ? data_q[7:0]  : 8'bz;

  // Next-state logic: read request tracking and latency countdown.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    load    = 1'b0;
    rd_inc  = 1'b0;
    new_req = 1'b0;
    case (state_q)
      ST_IDLE: new_req = rd;
      ST_WAIT: begin
        if (wr || !rd) begin
          state_d = ST_IDLE;
        end else if (SRAM_ADDR != addr_q) begin
          addr_d  = SRAM_ADDR;
          count_d = CNT_W'(LAT_RELOAD);
          rd_inc  = 1'b1;
        end else if (count_q == '0) begin
          load    = 1'b1;
          state_d = ST_DRIVE;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      ST_DRIVE: begin
        if (wr || !rd) begin
          state_d = ST_IDLE;
        end else if (SRAM_ADDR != addr_q) begin
          new_req = 1'b1;
        end else begin
          // Reload every cycle so writes from elsewhere are reflected.
          load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (new_req) begin
      addr_d = SRAM_ADDR;
      rd_inc = 1'b1;
      if (READ_LAT == 1) begin
        load    = 1'b1;
        state_d = ST_DRIVE;
      end else begin
        count_d = CNT_W'(LAT_RELOAD);
        state_d = ST_WAIT;
      end
    end
  end

  // State, read data and status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_count  <= '0;
      rd_count  <= '0;
      proto_err <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      if (load)   data_q    <= mem[idx];
      if (wr)     wr_count  <= wr_count + 16'd1;
      if (rd_inc) rd_count  <= rd_count + 16'd1;
      if (err_c)  proto_err <= 1'b1;
    end
  end

  // Array is not cleared by reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst && wr) begin
      if (!SRAM_UB_N) mem[idx][15:8] <= SRAM_DQ[15:8];
      if (!SRAM_LB_N) mem[idx][7:0]  <= SRAM_DQ[7:0];
    end
  end

endmodule
